// File: rtl/lamp_switch_ctrl.sv
// Three-way staircase lamp controller: synchronizes and debounces S1..S3 and toggles F on every odd-parity change.
// Define LAMP_AUTO_OFF_EN to build the auto-off hold timer and the timeout pulse.
module lamp_switch_ctrl #(
   parameter int DEB_CYCLES  = 4,
   parameter int HOLD_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       S1,
   input  logic       S2,
   input  logic       S3,
   output logic       F,
   output logic [2:0] sw_db,
   output logic       toggle,
   output logic       timeout
);

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } lamp_state_t;

   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   logic [2:0]      sw_meta;
   logic [2:0]      sw_sync;
   logic [2:0]      sw_prev;
   logic [2:0][7:0] cnt;
   lamp_state_t     state;
   lamp_state_t     state_nxt;
   logic            chg;
   logic            expire;

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= {S3, S2, S1};
         sw_sync <= sw_meta;
      end
   end

   // A level is accepted only after DEB_CYCLES consecutive differing edges; any bounce back restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_db <= '0;
         cnt   <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sw_sync[i] == sw_db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               sw_db[i] <= sw_sync[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_prev <= '0;
      end else begin
         sw_prev <= sw_db;
      end
   end

   assign chg = ^(sw_db ^ sw_prev);

`ifdef LAMP_AUTO_OFF_EN
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

   logic [15:0] hold_cnt;

   // A switch change wins over a simultaneous expiry, so toggle and timeout never coincide.
   assign expire = (state == ON) && !chg && (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= expire;
         if (state != ON || chg) begin
            hold_cnt <= '0;
         end else begin
            hold_cnt <= hold_cnt + 16'd1;
         end
      end
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= OFF;
         toggle <= 1'b0;
      end else begin
         state  <= state_nxt;
         toggle <= chg;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OFF:     if (chg) state_nxt = ON;
         ON:      if (chg || expire) state_nxt = OFF;
         default: state_nxt = OFF;
      endcase
   end

   assign F = (state == ON);

   // Parameter ranges are checked in simulation only.
   always_ff @(posedge clk) begin
      param_legal: assert (DEB_CYCLES >= 1 && DEB_CYCLES <= 255 &&
                           HOLD_CYCLES >= 1 && HOLD_CYCLES <= 65535);
   end

endmodule
